// File: rtl/ucode_sequencer.sv
// Microcode ROM sequencer for decode stage 1.
// Steps a captured sequence id through its micro-ops, plus halt and interrupt entry.
module ucode_sequencer #(
  parameter int          IADDRW  = 32,
  parameter logic [31:0] SEQ_LEN = 32'h05214232
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              seq_valid,
  output logic              seq_ready,
  input  logic [2:0]        seq_id,
  input  logic [IADDRW-1:0] seq_pc,
  output logic              uop_valid,
  input  logic              uop_ready,
  output logic [2:0]        uop_seq,
  output logic [3:0]        uop_step,
  output logic              uop_first,
  output logic              uop_last,
  output logic [IADDRW-1:0] uop_pc,
  output logic              busy,
  output logic              halt,
  output logic              handle_int_done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        seq_q, seq_d;
  logic [3:0]        step_q, step_d;
  logic [IADDRW-1:0] pc_q, pc_d;
  logic [3:0]        len_raw;
  logic [3:0]        last_step;
  logic              fire;

  // A zero-length entry still issues one micro-op
  always_comb begin
    len_raw   = SEQ_LEN[{seq_q, 2'b00} +: 4];
    last_step = (len_raw == 4'd0) ? 4'd0 : len_raw - 4'd1;
  end

  assign uop_valid = (state_q == RUN);
  assign uop_seq   = seq_q;
  assign uop_step  = step_q;
  assign uop_pc    = pc_q;
  assign uop_first = (step_q == 4'd0);
  assign uop_last  = (step_q == last_step);
  assign busy      = (state_q != IDLE);
  assign halt      = (state_q == HALT);
  assign fire      = uop_valid & uop_ready;

  assign seq_ready       = fire & uop_last & ~flush & ~reset;
  assign handle_int_done = seq_ready & (seq_q == 3'd6);

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    step_d  = step_q;
    pc_d    = pc_q;
    if (flush) begin
      state_d = IDLE;
      step_d  = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (seq_valid) begin
            if (seq_id == 3'd7) begin
              state_d = HALT;
            end else begin
              state_d = RUN;
              seq_d   = seq_id;
              pc_d    = seq_pc;
              step_d  = 4'd0;
            end
          end
        end
        RUN: begin
          if (fire) begin
            if (uop_last) begin
              state_d = IDLE;
              step_d  = 4'd0;
            end else begin
              step_d = step_q + 4'd1;
            end
          end
        end
        HALT: state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      seq_q   <= 3'd0;
      step_q  <= 4'd0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      step_q  <= step_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer.
// Cycle model plus directed literal expectations.
module tb_ucode_sequencer;

  logic        clk = 0;
  logic        reset = 1;
  logic        flush = 0;
  logic        seq_valid = 0;
  logic        seq_ready;
  logic [2:0]  seq_id = 0;
  logic [31:0] seq_pc = 0;
  logic        uop_valid;
  logic        uop_ready = 0;
  logic [2:0]  uop_seq;
  logic [3:0]  uop_step;
  logic        uop_first;
  logic        uop_last;
  logic [31:0] uop_pc;
  logic        busy;
  logic        halt;
  logic        handle_int_done;

  ucode_sequencer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .seq_valid(seq_valid), .seq_ready(seq_ready),
    .seq_id(seq_id), .seq_pc(seq_pc),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_seq(uop_seq), .uop_step(uop_step),
    .uop_first(uop_first), .uop_last(uop_last),
    .uop_pc(uop_pc), .busy(busy), .halt(halt),
    .handle_int_done(handle_int_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Sequence lengths written out from the default table
  int len_tab[8] = '{2, 3, 2, 4, 1, 2, 5, 1};

  // 0 idle, 1 running, 2 halted
  int          m_mode = 0;
  int          m_seq = 0;
  int          m_step = 0;
  logic [31:0] m_pc = 0;
  bit          cmp_en = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_seq = 0; m_step = 0; m_pc = 0;
    end else if (flush) begin
      m_mode = 0; m_step = 0;
    end else if (m_mode == 0) begin
      if (seq_valid && seq_id == 3'd7) m_mode = 2;
      else if (seq_valid) begin
        m_mode = 1; m_seq = seq_id;
        m_pc = seq_pc; m_step = 0;
      end
    end else if (m_mode == 1 && uop_ready) begin
      if (m_step == len_tab[m_seq] - 1) begin
        m_mode = 0; m_step = 0;
      end else m_step++;
    end
  end

  int step_log[$];
  int rdy_cnt = 0;
  int hid_cnt = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      logic e_rdy;
      e_rdy = (m_mode == 1) && uop_ready && !flush && !reset &&
              (m_step == len_tab[m_seq] - 1);
      chk("uop_valid", uop_valid, m_mode == 1);
      chk("busy", busy, m_mode != 0);
      chk("halt", halt, m_mode == 2);
      chk("seq_ready", seq_ready, e_rdy);
      chk("int_done", handle_int_done, e_rdy && m_seq == 6);
      if (m_mode == 1) begin
        chk("uop_seq", uop_seq, m_seq);
        chk("uop_step", uop_step, m_step);
        chk("uop_pc", uop_pc, m_pc);
        chk("uop_first", uop_first, m_step == 0);
        chk("uop_last", uop_last,
            m_step == len_tab[m_seq] - 1);
      end
    end
    if (uop_valid) step_log.push_back(int'(uop_step));
    if (seq_ready) rdy_cnt++;
    if (handle_int_done) hid_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    step_log.delete();
    rdy_cnt = 0;
  endtask

  task automatic start(input logic [2:0] id, input logic [31:0] pc);
    seq_valid = 1; seq_id = id; seq_pc = pc;
    tick();
    seq_valid = 0; seq_id = 0; seq_pc = 32'hdead_beef;
  endtask

  task automatic chk_log(input string nm, input int exp[$]);
    chk({nm, "_len"}, step_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < step_log.size(); i++)
      chk(nm, step_log[i], exp[i]);
  endtask

  int pat[6] = '{1, 0, 0, 1, 1, 1};

  initial begin
    tick(2);
    cmp_en = 1;
    chk("rst_valid", uop_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halt", halt, 0);
    chk("rst_rdy", seq_ready, 0);
    chk("rst_seq", uop_seq, 0);
    chk("rst_step", uop_step, 0);
    chk("rst_pc", uop_pc, 0);
    reset = 0;
    tick();

    // T1: seq 1 with ready held
    clr(); hid_cnt = 0;
    uop_ready = 1;
    start(3'd1, 32'h1000);
    tick(4);
    chk_log("t1_step", '{0, 1, 2});
    chk("t1_rdy_cnt", rdy_cnt, 1);
    chk("t1_busy", busy, 0);

    // T2: seq 3 with stalls
    clr();
    start(3'd3, 32'h2000);
    for (int i = 0; i < 6; i++) begin
      uop_ready = pat[i][0];
      tick();
    end
    uop_ready = 1;
    tick(2);
    chk_log("t2_step", '{0, 1, 1, 1, 2, 3});
    chk("t2_rdy_cnt", rdy_cnt, 1);
    chk("t12_int_cnt", hid_cnt, 0);

    // T3: interrupt entry
    clr(); hid_cnt = 0;
    start(3'd6, 32'h0300);
    tick(7);
    chk_log("t3_step", '{0, 1, 2, 3, 4});
    chk("t3_int_cnt", hid_cnt, 1);
    chk("t3_rdy_cnt", rdy_cnt, 1);

    // T4: halt until flush
    clr();
    start(3'd7, 32'h0);
    tick(5);
    chk("t4_halt", halt, 1);
    chk("t4_valid", uop_valid, 0);
    chk("t4_rdy_cnt", rdy_cnt, 0);
    flush = 1;
    tick();
    flush = 0;
    chk("t4_halt_off", halt, 0);
    chk("t4_busy", busy, 0);
    tick();

    // T5: flush at step 1 with final handshake
    clr(); hid_cnt = 0;
    start(3'd0, 32'h5000);
    tick();
    flush = 1;
    tick();
    flush = 0;
    chk("t5_busy", busy, 0);
    chk("t5_rdy_cnt", rdy_cnt, 0);
    tick();
    clr();
    start(3'd4, 32'h4444);
    tick(2);
    chk_log("t5_step", '{0});
    chk("t5_rdy_cnt2", rdy_cnt, 1);

    // T6: reset mid-sequence
    start(3'd3, 32'h6000);
    tick(2);
    chk("t6_step2", uop_step, 2);
    reset = 1; seq_valid = 1; seq_id = 3'd2;
    tick();
    chk("t6_valid", uop_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_step", uop_step, 0);
    chk("t6_pc", uop_pc, 0);
    chk("t6_seq", uop_seq, 0);
    tick();
    chk("t6_busy2", busy, 0);
    reset = 0; seq_valid = 0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
